// File: rtl/dc_fu_dma_pkg.sv
// Shared types and helpers for the fetching-unit DMA frame address generator.
package dc_fu_dma_pkg;

    typedef enum logic [1:0] {
        AG_IDLE  = 2'd0,
        AG_CALC  = 2'd1,
        AG_ISSUE = 2'd2,
        AG_DONE  = 2'd3
    } dc_fu_dma_ag_state_t;

    // Default beat size and burst cap; the generator's parameters default from these.
    localparam int BEAT_BYTES = 2;
    localparam int MAX_BEATS  = 16;

    function automatic logic [31:0] min3(input logic [31:0] a,
                                         input logic [31:0] b,
                                         input logic [31:0] c);
        logic [31:0] m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

endpackage

// File: rtl/dc_fu_dma_burst_len_calc.sv
// Combinational burst sizing: clamps a burst to the remaining beats, the burst cap
// and the distance to the next no-cross boundary.
module dc_fu_dma_burst_len_calc
    import dc_fu_dma_pkg::*;
#(
    parameter int AXI_ARADDR_WIDTH = 32,
    parameter int WORDS_WIDTH      = 17,
    parameter int MAX_BURST_LEN    = 4,
    parameter int READ_DATA_SIZE   = 1,
    parameter int BOUNDARY_LOG2    = 12
) (
    input  logic [AXI_ARADDR_WIDTH-1:0] cur_addr,
    input  logic [WORDS_WIDTH-1:0]      words_left,
    output logic [MAX_BURST_LEN:0]      len,
    output logic [7:0]                  arlen
);

    logic [31:0] offset;
    logic [31:0] to_bound;
    logic [31:0] min_w;
    logic        unused_addr_hi;

    // Only the offset inside the boundary window matters for the clamp.
    assign unused_addr_hi = ^cur_addr[AXI_ARADDR_WIDTH-1:BOUNDARY_LOG2];

    always_comb begin
        offset   = 32'(cur_addr[BOUNDARY_LOG2-1:0]);
        to_bound = ((32'd1 << BOUNDARY_LOG2) - offset) >> READ_DATA_SIZE;
        min_w    = min3(32'(words_left), 32'd1 << MAX_BURST_LEN, to_bound);
        len      = min_w[MAX_BURST_LEN:0];
        arlen    = 8'(min_w - 32'd1);
    end

endmodule

// File: rtl/dc_fu_dma_frame_addr_gen.sv
// Frame-level AXI AR generator: walks line_count lines of a 2-D frame and emits
// boundary-safe bursts with a full valid/ready handshake.
module dc_fu_dma_frame_addr_gen
    import dc_fu_dma_pkg::*;
#(
    parameter int FETCH_WORD_COUNT_WIDTH = 16,
    parameter int LINE_COUNT_WIDTH       = 12,
    parameter int AXI_ARADDR_WIDTH       = 32,
    parameter int MAX_BURST_LEN          = $clog2(MAX_BEATS),
    parameter int READ_DATA_SIZE         = $clog2(BEAT_BYTES),
    parameter int BOUNDARY_LOG2          = 12
) (
    input  logic                              clk,
    input  logic                              nrst,
    input  logic                              en,
    input  logic                              start_fetch,
    input  logic [FETCH_WORD_COUNT_WIDTH-1:0] fetch_word_count,
    input  logic [LINE_COUNT_WIDTH-1:0]       line_count,
    input  logic [AXI_ARADDR_WIDTH-1:0]       base_addr,
    input  logic [AXI_ARADDR_WIDTH-1:0]       line_stride,
    output logic                              busy,
    output logic                              done,
    output logic                              unaligned_read,
    output logic                              axi_arvalid,
    input  logic                              axi_arready,
    output logic [AXI_ARADDR_WIDTH-1:0]       axi_araddr,
    output logic [7:0]                        axi_arlen,
    output logic [FETCH_WORD_COUNT_WIDTH:0]   words_left,
    output logic [LINE_COUNT_WIDTH-1:0]       lines_left
);

    localparam int WLW = FETCH_WORD_COUNT_WIDTH + 1;
    localparam int AW  = AXI_ARADDR_WIDTH;
    localparam logic [AW-1:0] LOW_MASK = AW'((1 << READ_DATA_SIZE) - 1);

    dc_fu_dma_ag_state_t    state;
    logic [AW-1:0]          cur_addr;
    logic [AW-1:0]          line_base;
    logic [AW-1:0]          stride_r;
    logic [WLW-1:0]         beats_per_line;
    logic [MAX_BURST_LEN:0] len_r;
    logic                   valid_r;

    logic [MAX_BURST_LEN:0] calc_len;
    logic [7:0]             calc_arlen;
    logic                   start_unal;
    logic [WLW-1:0]         start_beats;
    logic [WLW-1:0]         next_words;
    logic [AW-1:0]          next_addr;
    logic [AW-1:0]          next_line;

    dc_fu_dma_burst_len_calc #(
        .AXI_ARADDR_WIDTH (AW),
        .WORDS_WIDTH      (WLW),
        .MAX_BURST_LEN    (MAX_BURST_LEN),
        .READ_DATA_SIZE   (READ_DATA_SIZE),
        .BOUNDARY_LOG2    (BOUNDARY_LOG2)
    ) u_burst_len_calc (
        .cur_addr   (cur_addr),
        .words_left (words_left),
        .len        (calc_len),
        .arlen      (calc_arlen)
    );

    // A misaligned base costs one extra beat to cover the trailing partial word.
    assign start_unal  = |base_addr[READ_DATA_SIZE-1:0];
    assign start_beats = {1'b0, fetch_word_count} + WLW'(start_unal);
    assign next_words  = words_left - WLW'(len_r);
    assign next_addr   = cur_addr + (AW'(len_r) << READ_DATA_SIZE);
    assign next_line   = line_base + stride_r;

    assign axi_arvalid = valid_r && en;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state          <= AG_IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            unaligned_read <= 1'b0;
            valid_r        <= 1'b0;
            axi_araddr     <= '0;
            axi_arlen      <= '0;
            words_left     <= '0;
            lines_left     <= '0;
            cur_addr       <= '0;
            line_base      <= '0;
            stride_r       <= '0;
            beats_per_line <= '0;
            len_r          <= '0;
        end else if (en) begin
            case (state)
                AG_IDLE: begin
                    if (start_fetch) begin
                        unaligned_read <= start_unal;
                        if (fetch_word_count == '0 || line_count == '0) begin
                            words_left <= '0;
                            lines_left <= '0;
                            done       <= 1'b1;
                            state      <= AG_DONE;
                        end else begin
                            line_base      <= base_addr & ~LOW_MASK;
                            cur_addr       <= base_addr & ~LOW_MASK;
                            stride_r       <= line_stride;
                            beats_per_line <= start_beats;
                            words_left     <= start_beats;
                            lines_left     <= line_count;
                            busy           <= 1'b1;
                            state          <= AG_CALC;
                        end
                    end
                end
                AG_CALC: begin
                    axi_araddr <= cur_addr;
                    axi_arlen  <= calc_arlen;
                    len_r      <= calc_len;
                    valid_r    <= 1'b1;
                    state      <= AG_ISSUE;
                end
                AG_ISSUE: begin
                    if (axi_arready) begin
                        valid_r <= 1'b0;
                        if (next_words != '0) begin
                            cur_addr   <= next_addr;
                            words_left <= next_words;
                            state      <= AG_CALC;
                        end else if (lines_left > LINE_COUNT_WIDTH'(1)) begin
                            line_base  <= next_line;
                            cur_addr   <= next_line;
                            words_left <= beats_per_line;
                            lines_left <= lines_left - LINE_COUNT_WIDTH'(1);
                            state      <= AG_CALC;
                        end else begin
                            words_left <= '0;
                            lines_left <= '0;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                            state      <= AG_DONE;
                        end
                    end
                end
                AG_DONE: begin
                    done  <= 1'b0;
                    state <= AG_IDLE;
                end
                default: state <= AG_IDLE;
            endcase
        end
    end

    // Dropping en under a pending AR would retract a valid, which AXI forbids.
    a_en_hold: assert property (@(posedge clk) disable iff (!nrst)
        !(busy && valid_r && !en))
        else $error("en deasserted while an AR request is pending");

endmodule

// File: tb/tb_dc_fu_dma_frame_addr_gen.sv
// Directed and randomized frames checked against a burst-list model of the frame walk.
module tb_dc_fu_dma_frame_addr_gen;

    logic        clk = 1'b0;
    logic        nrst;
    logic        en;
    logic        start_fetch;
    logic [15:0] fetch_word_count;
    logic [11:0] line_count;
    logic [31:0] base_addr;
    logic [31:0] line_stride;
    logic        busy;
    logic        done;
    logic        unaligned_read;
    logic        axi_arvalid;
    logic        axi_arready;
    logic [31:0] axi_araddr;
    logic [7:0]  axi_arlen;
    logic [16:0] words_left;
    logic [11:0] lines_left;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  arlen;
        logic [11:0] ll;
        logic [16:0] wl;
    } burst_t;

    burst_t exp_q[$];
    burst_t obs_q[$];

    dc_fu_dma_frame_addr_gen dut (
        .clk              (clk),
        .nrst             (nrst),
        .en               (en),
        .start_fetch      (start_fetch),
        .fetch_word_count (fetch_word_count),
        .line_count       (line_count),
        .base_addr        (base_addr),
        .line_stride      (line_stride),
        .busy             (busy),
        .done             (done),
        .unaligned_read   (unaligned_read),
        .axi_arvalid      (axi_arvalid),
        .axi_arready      (axi_arready),
        .axi_araddr       (axi_araddr),
        .axi_arlen        (axi_arlen),
        .words_left       (words_left),
        .lines_left       (lines_left)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Frame as a flat list of bursts: 2-byte beats, 16-beat cap, 4 KiB no-cross windows.
    function automatic void build_model(input logic [31:0] base, input logic [31:0] stride,
                                        input int wc, input int lc);
        longint unsigned line0, a;
        int rem, n, to_b, beats;
        burst_t b;
        exp_q.delete();
        if (wc == 0 || lc == 0) return;
        line0 = {32'd0, base & 32'hFFFF_FFFE};
        beats = wc + int'(base[0]);
        for (int l = 0; l < lc; l++) begin
            a   = (line0 + 64'(l) * {32'd0, stride}) & 64'hFFFF_FFFF;
            rem = beats;
            while (rem > 0) begin
                to_b = int'((64'd4096 - (a % 64'd4096)) / 64'd2);
                n = rem;
                if (n > 16) n = 16;
                if (n > to_b) n = to_b;
                b.addr  = a[31:0];
                b.arlen = 8'(n - 1);
                b.ll    = 12'(lc - l);
                b.wl    = 17'(rem);
                exp_q.push_back(b);
                a   = (a + 64'(2 * n)) & 64'hFFFF_FFFF;
                rem -= n;
            end
        end
    endfunction

    // Called just after a falling edge; returns just after a falling edge with the block idle.
    task automatic run_frame(input logic [31:0] base, input logic [31:0] stride,
                             input int wc, input int lc, input int stall,
                             input int rdy_pct, input bit poke, input string tag);
        int first_v, done_cyc, last_hs, stalled, done_cnt;
        bit nonempty, hold;
        logic [31:0] hold_addr;
        logic [7:0]  hold_len;
        burst_t e, o;
        build_model(base, stride, wc, lc);
        obs_q.delete();
        nonempty = (wc != 0 && lc != 0);
        start_fetch = 1'b1; base_addr = base; line_stride = stride;
        fetch_word_count = 16'(wc); line_count = 12'(lc);
        @(negedge clk);
        start_fetch = 1'b0;
        first_v = -1; done_cyc = -1; last_hs = -1; stalled = 0; done_cnt = 0; hold = 1'b0;
        hold_addr = '0; hold_len = '0;
        for (int c = 0; c < 3000; c++) begin
            if (poke && c == 3) begin
                start_fetch = 1'b1; base_addr = 32'hDEAD_0000;
                fetch_word_count = 16'd5; line_count = 12'd1;
            end else if (poke && c == 4) begin
                start_fetch = 1'b0;
            end
            #1;
            if (axi_arvalid && first_v < 0) first_v = c;
            if (hold) begin
                chk({tag, "_hold_valid"}, 64'(axi_arvalid), 64'd1);
                chk({tag, "_hold_addr"}, 64'(axi_araddr), 64'(hold_addr));
                chk({tag, "_hold_len"}, 64'(axi_arlen), 64'(hold_len));
            end
            axi_arready = (axi_arvalid && stalled < stall) ? 1'b0
                        : ($urandom_range(99) < 32'(rdy_pct));
            hold = axi_arvalid && !axi_arready;
            if (hold) begin
                stalled++; hold_addr = axi_araddr; hold_len = axi_arlen;
            end
            if (axi_arvalid && axi_arready) begin
                if (exp_q.size() == 0) begin
                    chk({tag, "_extra_ar"}, 64'(axi_araddr), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk({tag, "_araddr"}, 64'(axi_araddr), 64'(e.addr));
                    chk({tag, "_arlen"}, 64'(axi_arlen), 64'(e.arlen));
                    chk({tag, "_lines_left"}, 64'(lines_left), 64'(e.ll));
                    chk({tag, "_words_left"}, 64'(words_left), 64'(e.wl));
                end
                o.addr = axi_araddr; o.arlen = axi_arlen; o.ll = lines_left; o.wl = words_left;
                obs_q.push_back(o);
                last_hs = c;
            end
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            chk({tag, "_busy"}, 64'(busy), 64'(nonempty && done_cyc < 0));
            if (done_cyc >= 0 && c >= done_cyc + 2) break;
            @(negedge clk);
        end
        axi_arready = 1'b0;
        chk({tag, "_done_once"}, 64'(done_cnt), 64'd1);
        chk({tag, "_bursts_left"}, 64'(exp_q.size()), 64'd0);
        chk({tag, "_unaligned"}, 64'(unaligned_read), 64'(base[0]));
        chk({tag, "_lines_end"}, 64'(lines_left), 64'd0);
        if (nonempty) begin
            chk({tag, "_first_ar_lat"}, 64'(first_v), 64'd1);
            chk({tag, "_done_lat"}, 64'(done_cyc), 64'(last_hs + 1));
        end else begin
            chk({tag, "_no_ar"}, 64'(first_v < 0), 64'd1);
            chk({tag, "_done_lat"}, 64'(done_cyc), 64'd0);
        end
    endtask

    initial begin
        logic [31:0] rb, rs;
        int rwc, rlc;
        nrst = 1'b0; en = 1'b1; start_fetch = 1'b0; axi_arready = 1'b0;
        fetch_word_count = '0; line_count = '0; base_addr = '0; line_stride = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_arvalid", 64'(axi_arvalid), 64'd0);
        chk("rst_araddr", 64'(axi_araddr), 64'd0);
        chk("rst_arlen", 64'(axi_arlen), 64'd0);
        chk("rst_words", 64'(words_left), 64'd0);
        chk("rst_lines", 64'(lines_left), 64'd0);
        chk("rst_unal", 64'(unaligned_read), 64'd0);
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);

        run_frame(32'h1000, 32'h0, 40, 1, 0, 100, 1'b0, "basic");
        chk("basic_n", 64'(obs_q.size()), 64'd3);
        if (obs_q.size() == 3) begin
            chk("basic_a0", 64'(obs_q[0].addr), 64'h1000);
            chk("basic_l0", 64'(obs_q[0].arlen), 64'd15);
            chk("basic_a1", 64'(obs_q[1].addr), 64'h1020);
            chk("basic_a2", 64'(obs_q[2].addr), 64'h1040);
            chk("basic_l2", 64'(obs_q[2].arlen), 64'd7);
        end

        run_frame(32'h0FF8, 32'h0, 16, 1, 0, 100, 1'b0, "bound");
        chk("bound_n", 64'(obs_q.size()), 64'd2);
        if (obs_q.size() == 2) begin
            chk("bound_l0", 64'(obs_q[0].arlen), 64'd3);
            chk("bound_a1", 64'(obs_q[1].addr), 64'h1000);
            chk("bound_l1", 64'(obs_q[1].arlen), 64'd11);
        end

        run_frame(32'h2000, 32'h400, 16, 3, 0, 100, 1'b0, "multi");
        chk("multi_n", 64'(obs_q.size()), 64'd3);
        if (obs_q.size() == 3) begin
            chk("multi_a1", 64'(obs_q[1].addr), 64'h2400);
            chk("multi_a2", 64'(obs_q[2].addr), 64'h2800);
            chk("multi_ll2", 64'(obs_q[2].ll), 64'd1);
        end

        run_frame(32'h3001, 32'h0, 4, 1, 0, 100, 1'b0, "unal");
        chk("unal_n", 64'(obs_q.size()), 64'd1);
        if (obs_q.size() == 1) begin
            chk("unal_a0", 64'(obs_q[0].addr), 64'h3000);
            chk("unal_l0", 64'(obs_q[0].arlen), 64'd4);
        end

        run_frame(32'h1000, 32'h0, 40, 1, 5, 100, 1'b0, "bp");
        run_frame(32'h1000, 32'h0, 0, 1, 0, 100, 1'b0, "wc0");
        run_frame(32'h1000, 32'h0, 8, 0, 0, 100, 1'b0, "lc0");
        run_frame(32'h4000, 32'h800, 100, 2, 0, 80, 1'b1, "busy_start");

        // A start while en is low must not be taken.
        en = 1'b0; start_fetch = 1'b1; fetch_word_count = 16'd8; line_count = 12'd1;
        @(negedge clk);
        start_fetch = 1'b0; en = 1'b1;
        @(negedge clk);
        #1;
        chk("en_gate_busy", 64'(busy), 64'd0);
        chk("en_gate_arvalid", 64'(axi_arvalid), 64'd0);
        @(negedge clk);

        // Asynchronous reset in the middle of a frame.
        axi_arready = 1'b1;
        start_fetch = 1'b1; base_addr = 32'h5001; line_stride = 32'h100;
        fetch_word_count = 16'd60; line_count = 12'd2;
        @(negedge clk);
        start_fetch = 1'b0;
        repeat (4) @(negedge clk);
        #2 nrst = 1'b0;
        #1;
        chk("mrst_busy", 64'(busy), 64'd0);
        chk("mrst_done", 64'(done), 64'd0);
        chk("mrst_arvalid", 64'(axi_arvalid), 64'd0);
        chk("mrst_araddr", 64'(axi_araddr), 64'd0);
        chk("mrst_words", 64'(words_left), 64'd0);
        chk("mrst_lines", 64'(lines_left), 64'd0);
        chk("mrst_unal", 64'(unaligned_read), 64'd0);
        axi_arready = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        run_frame(32'h6000, 32'h200, 20, 2, 0, 100, 1'b0, "post_rst");

        for (int i = 0; i < 20; i++) begin
            rb = $urandom;
            if (i % 3 == 0) rb[11:0] = 12'hFC0 | 12'($urandom_range(63));
            rs = $urandom_range(32'h3000) & 32'hFFFF_FFFE;
            rwc = $urandom_range(70);
            rlc = $urandom_range(4);
            run_frame(rb, rs, rwc, rlc, i % 4, 60, 1'b0, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
